// File: rtl/debouncer_multi_if.sv
// Bundles the sample strobe, raw switch inputs and debounced outputs of debouncer_multi.
// The design side uses the slave modport; whoever drives the switches uses master.
interface debouncer_multi_if #(
    parameter int CHANNELS = 4
);
    logic                SampleEn;
    logic [CHANNELS-1:0] SwIn;
    logic [CHANNELS-1:0] SwOutDB;
    logic [CHANNELS-1:0] SwRise;
    logic [CHANNELS-1:0] SwFall;
    logic [CHANNELS-1:0] Busy;

    modport master (
        output SampleEn,
        output SwIn,
        input  SwOutDB,
        input  SwRise,
        input  SwFall,
        input  Busy
    );

    modport slave (
        input  SampleEn,
        input  SwIn,
        output SwOutDB,
        output SwRise,
        output SwFall,
        output Busy
    );
endinterface

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: a 2-flop synchroniser per channel feeds a strobe-gated
// agreement counter; a change is accepted after STABLE_CNT consecutive differing samples.
module debouncer_multi #(
    parameter int   CHANNELS   = 4,
    parameter int   STABLE_CNT = 4,
    parameter logic INIT_VAL   = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    debouncer_multi_if.slave bus
);
    localparam int                  CNT_W    = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_VAL}};

    logic [CHANNELS-1:0] swMeta_q;
    logic [CHANNELS-1:0] swSync_q;
    logic [CHANNELS-1:0] swDb_q;
    logic [CHANNELS-1:0] swDb_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] busy;

    // Any sample agreeing with the current output cancels a pending change, so the
    // counter can only reach CNT_LAST on an unbroken run and never wraps.
    always_comb begin
        swDb_d = swDb_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.SampleEn) begin
                if (swSync_q[i] == swDb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    swDb_d[i] = swSync_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = swSync_q[i];
                    fall_d[i] = ~swSync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchroniser runs every clock; everything downstream only moves on a strobe.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            swMeta_q <= INIT_VEC;
            swSync_q <= INIT_VEC;
            swDb_q   <= INIT_VEC;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            swMeta_q <= bus.SwIn;
            swSync_q <= swMeta_q;
            swDb_q   <= swDb_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign bus.SwOutDB = swDb_q;
    assign bus.SwRise  = rise_q;
    assign bus.SwFall  = fall_q;
    assign bus.Busy    = busy;
endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: one instance with STABLE_CNT=4 and one with STABLE_CNT=1,
// driven with identical stimulus and compared every cycle against a sample-history model.
module tb_debouncer_multi;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    debouncer_multi_if #(.CHANNELS(4)) bus4 ();
    debouncer_multi_if #(.CHANNELS(4)) bus1 ();

    debouncer_multi #(.CHANNELS(4), .STABLE_CNT(4), .INIT_VAL(1'b0)) dut4 (
        .Clk(Clk), .Rst(Rst), .bus(bus4.slave));
    debouncer_multi #(.CHANNELS(4), .STABLE_CNT(1), .INIT_VAL(1'b0)) dut1 (
        .Clk(Clk), .Rst(Rst), .bus(bus1.slave));

    typedef struct {
        logic [3:0] sw;
        logic       en;
        logic [3:0] expOut;
        logic [3:0] expRise;
        logic [3:0] expFall;
        logic [3:0] expBusy;
    } vec_t;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: the raw input seen two clocks late, plus the most recent strobed
    // samples since reset; a channel flips when its last N samples all disagree with it.
    int         modelN [2] = '{4, 1};
    logic [3:0] syncQ[$];
    logic [3:0] mHist [2][4];
    int         mLen [2];
    logic [3:0] mOut [2];
    logic [3:0] mRise [2];
    logic [3:0] mFall [2];

    logic [3:0] curSw = 4'h0;
    logic       curEn = 1'b0;
    bit         countEn = 1'b0;
    logic [3:0] prevOut1 = 4'h0;
    int         pulses1 = 0;
    int         edges1 = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        syncQ.delete();
        syncQ.push_back(4'h0);
        syncQ.push_back(4'h0);
        for (int d = 0; d < 2; d++) begin
            mLen[d]  = 0;
            mOut[d]  = 4'h0;
            mRise[d] = 4'h0;
            mFall[d] = 4'h0;
        end
    endtask

    task automatic modelStep(input logic [3:0] sw, input logic en);
        logic [3:0] s;
        bit allDiffer;
        syncQ.push_front(sw);
        s = syncQ.pop_back();
        for (int d = 0; d < 2; d++) begin
            mRise[d] = 4'h0;
            mFall[d] = 4'h0;
            if (en) begin
                for (int j = 3; j > 0; j--) mHist[d][j] = mHist[d][j-1];
                mHist[d][0] = s;
                if (mLen[d] < 4) mLen[d]++;
                if (mLen[d] >= modelN[d]) begin
                    for (int c = 0; c < 4; c++) begin
                        allDiffer = 1'b1;
                        for (int j = 0; j < modelN[d]; j++)
                            if (mHist[d][j][c] == mOut[d][c]) allDiffer = 1'b0;
                        if (allDiffer) begin
                            mOut[d][c] = s[c];
                            if (s[c]) mRise[d][c] = 1'b1;
                            else      mFall[d][c] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [15:0] modelVec(input int d);
        logic [3:0] busy;
        busy = (mLen[d] > 0) ? (mHist[d][0] ^ mOut[d]) : 4'h0;
        return {mOut[d], mRise[d], mFall[d], busy};
    endfunction

    // One clock: drive at the low phase, update the model at the edge, compare on the next low phase.
    task automatic applyStimulus(input logic [3:0] sw, input logic en);
        curSw = sw;
        curEn = en;
        bus4.SwIn = sw;
        bus1.SwIn = sw;
        bus4.SampleEn = en;
        bus1.SampleEn = en;
        @(posedge Clk);
        if (Rst) modelReset();
        else     modelStep(sw, en);
        @(negedge Clk);
        checkOutput($sformatf("model dut4 t=%0t", $time),
                    {bus4.SwOutDB, bus4.SwRise, bus4.SwFall, bus4.Busy}, modelVec(0));
        checkOutput($sformatf("model dut1 t=%0t", $time),
                    {bus1.SwOutDB, bus1.SwRise, bus1.SwFall, bus1.Busy}, modelVec(1));
        if (countEn) begin
            edges1  += $countones(bus1.SwOutDB ^ prevOut1);
            pulses1 += $countones(bus1.SwRise | bus1.SwFall);
            prevOut1 = bus1.SwOutDB;
        end
    endtask

    task automatic resetPulse();
        #2 Rst = 1'b1;
        modelReset();
        applyStimulus(curSw, curEn);
        #2 Rst = 1'b0;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] sw, input logic en, input logic [3:0] o,
                                input logic [3:0] r, input logic [3:0] f, input logic [3:0] b);
        vec_t v;
        v.sw = sw; v.en = en; v.expOut = o; v.expRise = r; v.expFall = f; v.expBusy = b;
        return v;
    endfunction

    initial begin
        int k;
        logic [3:0] sw;
        modelReset();

        // Reset-release acceptance, bounce rejection, simultaneous rise/fall, strobe hold.
        repeat (2) vecs.push_back(mk(4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0));
        repeat (3) vecs.push_back(mk(4'hF, 1, 4'h0, 4'h0, 4'h0, 4'hF));
        vecs.push_back(mk(4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0));
        vecs.push_back(mk(4'hF, 1, 4'hF, 4'h0, 4'h0, 4'h0));
        repeat (2) vecs.push_back(mk(4'hE, 1, 4'hF, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'hE, 1, 4'hF, 4'h0, 4'h0, 4'h1));
        repeat (2) vecs.push_back(mk(4'hF, 1, 4'hF, 4'h0, 4'h0, 4'h1));
        vecs.push_back(mk(4'hF, 1, 4'hF, 4'h0, 4'h0, 4'h0));
        repeat (2) vecs.push_back(mk(4'hD, 1, 4'hF, 4'h0, 4'h0, 4'h0));
        repeat (3) vecs.push_back(mk(4'hD, 1, 4'hF, 4'h0, 4'h0, 4'h2));
        vecs.push_back(mk(4'hD, 1, 4'hD, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'hD, 1, 4'hD, 4'h0, 4'h0, 4'h0));
        repeat (2) vecs.push_back(mk(4'h7, 1, 4'hD, 4'h0, 4'h0, 4'h0));
        repeat (3) vecs.push_back(mk(4'h7, 1, 4'hD, 4'h0, 4'h0, 4'hA));
        vecs.push_back(mk(4'h7, 1, 4'h7, 4'h2, 4'h8, 4'h0));
        vecs.push_back(mk(4'h7, 1, 4'h7, 4'h0, 4'h0, 4'h0));
        repeat (4) vecs.push_back(mk(4'h0, 0, 4'h7, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 1, 4'h7, 4'h0, 4'h0, 4'h7));
        vecs.push_back(mk(4'h0, 0, 4'h7, 4'h0, 4'h0, 4'h7));
        vecs.push_back(mk(4'h0, 1, 4'h7, 4'h0, 4'h0, 4'h7));

        // Held in reset with all switches high: outputs stay at the reset value.
        applyStimulus(4'hF, 1'b1);
        applyStimulus(4'hF, 1'b1);
        checkOutput("reset hold", {bus4.SwOutDB, bus4.SwRise, bus4.SwFall, bus4.Busy}, 16'h0000);
        #2 Rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sw, vecs[i].en);
            checkOutput($sformatf("vec%0d", i),
                        {bus4.SwOutDB, bus4.SwRise, bus4.SwFall, bus4.Busy},
                        {vecs[i].expOut, vecs[i].expRise, vecs[i].expFall, vecs[i].expBusy});
        end

        // Strobe every 10 clocks: channel 2 is accepted on the 4th strobe, pulse lasts one clock.
        applyStimulus(4'h0, 1'b0);
        resetPulse();
        for (int s = 1; s <= 4; s++) begin
            repeat (9) applyStimulus(4'h4, 1'b0);
            applyStimulus(4'h4, 1'b1);
            checkOutput($sformatf("strobed s%0d", s), {bus4.SwOutDB, bus4.SwRise},
                        (s == 4) ? 8'h44 : 8'h00);
        end
        applyStimulus(4'h4, 1'b0);
        checkOutput("strobed pulse end", {bus4.SwOutDB, bus4.SwRise}, 8'h40);

        // Reset in the middle of a pending change throws the partial count away.
        resetPulse();
        repeat (4) applyStimulus(4'h1, 1'b1);
        checkOutput("midcount busy", {bus4.SwOutDB, bus4.Busy}, 8'h01);
        #2 Rst = 1'b1;
        modelReset();
        #1 checkOutput("midcount cleared", {bus4.SwOutDB, bus4.Busy, bus4.SwRise}, 12'h000);
        @(negedge Clk);
        #2 Rst = 1'b0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(4'h1, 1'b1);
            if (bus4.SwOutDB[0]) begin
                k = c;
                break;
            end
        end
        checkOutput("midcount relatency", 16'(k), 16'd6);
        checkOutput("midcount rise", {12'h0, bus4.SwRise}, 16'h0001);

        // STABLE_CNT=1 follows a step after two sync clocks plus one strobe.
        applyStimulus(4'h0, 1'b1);
        resetPulse();
        applyStimulus(4'hF, 1'b1);
        checkOutput("cnt1 step c1", {bus1.SwOutDB, bus1.SwRise}, 8'h00);
        applyStimulus(4'hF, 1'b1);
        checkOutput("cnt1 step c2", {bus1.SwOutDB, bus1.SwRise}, 8'h00);
        applyStimulus(4'hF, 1'b1);
        checkOutput("cnt1 step c3", {bus1.SwOutDB, bus1.SwRise}, 8'hFF);

        // Random toggling and strobing against the model; pulses must match output edges.
        prevOut1 = bus1.SwOutDB;
        countEn = 1'b1;
        sw = 4'hF;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 9) == 0) sw[c] = ~sw[c];
            applyStimulus(sw, ($urandom_range(0, 3) != 0));
        end
        countEn = 1'b0;
        checkOutput("cnt1 pulses vs edges", 16'(pulses1), 16'(edges1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
